muldiv_sched: RTL and testbench

MULDIV_SCHED -- requirements
Module: muldiv_sched

---
 rtl/muldiv_sched_pkg.sv | 30 +++
 rtl/muldiv_sched.sv | 151 +++++++++++++++
 tb/tb_muldiv_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the mul/div scheduler: op one-hot bit positions,
// FSM state encoding and the fast divide-by-zero result constants.
package muldiv_sched_pkg;

  localparam int OP_MUL   = 0;
  localparam int OP_MULH  = 1;
  localparam int OP_MULHU = 2;
  localparam int OP_DIV   = 3;
  localparam int OP_DIVU  = 4;
  localparam int OP_MOD   = 5;
  localparam int OP_MODU  = 6;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL   = 3'd1;
  localparam logic [2:0] ST_DIV   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

  function automatic logic op_is_onehot(input logic [6:0] op);
    return (op != 7'd0) && ((op & (op - 7'd1)) == 7'd0);
  endfunction

  // Remainder of x/0 is the dividend itself.
  function automatic logic [31:0] div0_result(input logic is_rem, input logic [31:0] dividend);
    return is_rem ? dividend : DIV0_QUOTIENT;
  endfunction

endpackage

// File: rtl/muldiv_sched.sv
// Single-issue mul/div scheduler in front of external multiplier/divider; mul result after MUL_LAT+1 cycles,
// div result the cycle after div_done; holds result until out_ready. MULDIV_SCHED_DIV0_FAST_EN bypasses x/0.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             mul_signed,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  input  logic [63:0]      mul_result,
  output logic             div_start,
  output logic             div_signed,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic [31:0]      div_s,
  input  logic [31:0]      div_r,
  input  logic             div_done
);

  localparam logic [2:0] LAT = 3'(MUL_LAT);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [2:0]       r_cnt;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic [31:0]      r_result;
  logic [TAG_W-1:0] r_tag;
  logic             r_mul_lo;
  logic             r_is_rem;
  logic             r_div_start;
  logic             r_mul_signed;
  logic             r_div_signed;

  logic w_accept;
  logic w_onehot;
  logic w_in_mul;
  logic w_in_div;
  logic w_div0;
  logic w_deliver;
  logic w_mul_last;

  assign in_ready   = (r_state == ST_IDLE) && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_onehot   = op_is_onehot(in_op);
  assign w_in_mul   = w_onehot && (in_op[OP_MUL] | in_op[OP_MULH] | in_op[OP_MULHU]);
  assign w_in_div   = w_onehot && (in_op[OP_DIV] | in_op[OP_DIVU] | in_op[OP_MOD] | in_op[OP_MODU]);
  assign w_deliver  = out_valid && out_ready;
  assign w_mul_last = (r_state == ST_MUL) && (r_cnt == 3'd1);

`ifdef MULDIV_SCHED_DIV0_FAST_EN
  assign w_div0 = w_in_div && (in_src2 == 32'd0);
`else
  assign w_div0 = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_in_mul)                 w_state_nxt = ST_MUL;
          else if (w_in_div && !w_div0) w_state_nxt = ST_DIV;
          else                          w_state_nxt = ST_DONE;
        end
      end
      ST_MUL: begin
        if (flush)           w_state_nxt = ST_IDLE;
        else if (w_mul_last) w_state_nxt = ST_DONE;
      end
      // The divider cannot abort, so a flush must wait out its completion
      // unless that completion is arriving in this very cycle.
      ST_DIV: begin
        if (flush)         w_state_nxt = div_done ? ST_IDLE : ST_DRAIN;
        else if (div_done) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (w_deliver || flush) w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_src1       <= 32'd0;
      r_src2       <= 32'd0;
      r_result     <= 32'd0;
      r_tag        <= '0;
      r_mul_lo     <= 1'b0;
      r_is_rem     <= 1'b0;
      r_div_start  <= 1'b0;
      r_mul_signed <= 1'b0;
      r_div_signed <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div_start <= w_accept && w_in_div && !w_div0;
      if (w_accept) begin
        r_src1       <= in_src1;
        r_src2       <= in_src2;
        r_tag        <= in_tag;
        r_mul_lo     <= in_op[OP_MUL];
        r_is_rem     <= in_op[OP_MOD] | in_op[OP_MODU];
        r_mul_signed <= in_op[OP_MUL] | in_op[OP_MULH];
        r_div_signed <= in_op[OP_DIV] | in_op[OP_MOD];
        r_cnt        <= LAT;
        // Malformed ops complete straight away with a zero result.
        r_result     <= w_div0 ? div0_result(in_op[OP_MOD] | in_op[OP_MODU], in_src1) : 32'd0;
      end else if (r_state == ST_MUL) begin
        r_cnt <= r_cnt - 3'd1;
        if (w_mul_last) r_result <= r_mul_lo ? mul_result[31:0] : mul_result[63:32];
      end else if ((r_state == ST_DIV) && div_done) begin
        r_result <= r_is_rem ? div_r : div_s;
      end
    end
  end

  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign mul_signed = r_mul_signed;
  assign mul_x      = r_src1;
  assign mul_y      = r_src2;
  assign div_start  = r_div_start;
  assign div_signed = r_div_signed;
  assign div_x      = r_src1;
  assign div_y      = r_src2;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed and randomized checks of muldiv_sched against an arithmetic reference,
// with a combinational multiplier and a 10-cycle divider model around the DUT.
module tb_muldiv_sched;

  localparam int MUL_LAT = 2;
  localparam int TAG_W   = 5;
`ifdef MULDIV_SCHED_DIV0_FAST_EN
  localparam bit DIV0_FAST = 1'b1;
`else
  localparam bit DIV0_FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic             mul_signed;
  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic [63:0]      mul_result;
  logic             div_start;
  logic             div_signed;
  logic [31:0]      div_x;
  logic [31:0]      div_y;
  logic [31:0]      div_s;
  logic [31:0]      div_r;
  logic             div_done;
  logic             stray_done;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int n_start   = 0;
  int n_deliv   = 0;
  int done_at   = -10;
  int dcnt;

  muldiv_sched #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag),
    .busy(busy),
    .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: RISC-V M-extension semantics.
  function automatic logic [31:0] ref_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      7'h01: begin p = sa * sb; return p[31:0]; end
      7'h02: begin p = sa * sb; return p[63:32]; end
      7'h04: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      7'h08: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      7'h10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      7'h20: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      7'h40: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    logic [63:0] xa;
    logic [63:0] ya;
    xa = {{32{mul_signed & mul_x[31]}}, mul_x};
    ya = {{32{mul_signed & mul_y[31]}}, mul_y};
    mul_result = xa * ya;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt  <= 0;
      div_s <= 32'd0;
      div_r <= 32'd0;
    end else if (div_start) begin
      dcnt  <= 10;
      div_s <= ref_op(div_signed ? 7'h08 : 7'h10, div_x, div_y);
      div_r <= ref_op(div_signed ? 7'h20 : 7'h40, div_x, div_y);
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
    end
  end
  assign div_done = (dcnt == 1) | stray_done;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) n_start <= n_start + 1;
    if (div_done) done_at <= cyc;
    if (out_valid && out_ready) n_deliv <= n_deliv + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tg);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin tick(); k++; end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tg;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output int t);
    t = 1;
    while (!out_valid && t < max) begin tick(); t++; end
    check("out_valid_seen", out_valid, 1);
  endtask

  int               t;
  int               bad;
  int               k;
  int               r;
  int               s0;
  int               d0;
  int               dly;
  logic [6:0]       op;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [31:0]      res0;
  logic [TAG_W-1:0] tg;
  logic [TAG_W-1:0] tag0;
  bit               is_mul;
  bit               is_div;
  bit               fast;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_op = 7'd0; in_src1 = 32'd0; in_src2 = 32'd0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b0; stray_done = 1'b0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_div_start", div_start, 0);
    check("rst_mul_x", mul_x, 0);

    // Accept possible at the first edge after release; mul 3 * -2.
    resetn = 1'b1;
    out_ready = 1'b1;
    d0 = n_deliv;
    issue(7'h01, 32'h0000_0003, 32'hFFFF_FFFE, 5'd7);
    check("s1_busy", busy, 1);
    wait_out(20, t);
    check("s1_latency", t, MUL_LAT + 1);
    check("s1_result", out_result, 32'hFFFF_FFFA);
    check("s1_tag", out_tag, 7);
    tick();
    check("s1_idle", busy, 0);
    check("s1_delivered", n_deliv - d0, 1);

    issue(7'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    check("s2_mulhu_unsigned", mul_signed, 0);
    wait_out(20, t);
    check("s2_mulhu", out_result, 32'hFFFF_FFFE);
    tick();
    issue(7'h02, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    check("s2_mulh_signed", mul_signed, 1);
    wait_out(20, t);
    check("s2_mulh", out_result, 32'h0000_0000);
    tick();

    // Signed remainder through the divider.
    s0 = n_start;
    issue(7'h20, 32'hFFFF_FFF9, 32'd2, 5'd3);
    check("s3_div_signed", div_signed, 1);
    wait_out(40, t);
    check("s3_result", out_result, 32'hFFFF_FFFF);
    check("s3_after_done", cyc, done_at + 1);
    tick();
    repeat (3) tick();
    check("s3_one_start", n_start - s0, 1);

    // Flush during a divide drains the divider silently.
    out_ready = 1'b0;
    d0 = n_deliv;
    issue(7'h10, 32'd100, 32'd7, 5'd4);
    tick(); tick();
    flush = 1'b1;
    check("s4_flush_blocks_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("s4_drain_busy", busy, 1);
    bad = 0; k = 0;
    while (!div_done && k < 40) begin
      if (out_valid || in_ready) bad++;
      tick(); k++;
    end
    check("s4_done_seen", div_done, 1);
    check("s4_quiet", bad, 0);
    check("s4_ready_at_done", in_ready, 0);
    tick();
    check("s4_ready_after", in_ready, 1);
    check("s4_no_valid", out_valid, 0);
    check("s4_no_delivery", n_deliv - d0, 0);

    // Result held under backpressure, then flush+out_ready delivers once.
    issue(7'h01, 32'h1234_5678, 32'h0000_0010, 5'd21);
    wait_out(20, t);
    res0 = out_result; tag0 = out_tag;
    check("s5_result", res0, 32'h2345_6780);
    bad = 0;
    repeat (5) begin
      tick();
      if (out_result !== res0 || out_tag !== tag0 || !out_valid || in_ready) bad++;
    end
    check("s5_held", bad, 0);
    d0 = n_deliv;
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("s5_delivered_once", n_deliv - d0, 1);
    check("s5_valid_low", out_valid, 0);

    // Flush in MUL, flush in DONE, flush blocking an accept, stray div_done.
    issue(7'h01, 32'd5, 32'd6, 5'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bad = 0;
    repeat (4) begin if (out_valid || busy) bad++; tick(); end
    check("flush_mul_dropped", bad, 0);
    d0 = n_deliv;
    issue(7'h00, 32'd1, 32'd2, 5'd6);
    check("bad_op_valid", out_valid, 1);
    check("bad_op_result", out_result, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_done_dropped", out_valid, 0);
    check("flush_done_no_delivery", n_deliv - d0, 0);
    in_valid = 1'b1; in_op = 7'h01; flush = 1'b1;
    check("flush_accept_ready", in_ready, 0);
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_none", busy, 0);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("stray_done_ignored", busy, 0);

    // Asynchronous reset in the middle of a divide.
    issue(7'h08, 32'd1000, 32'd3, 5'd9);
    tick(); tick();
    check("s6_busy_pre", busy, 1);
    #2 resetn = 1'b0;
    #1;
    check("s6_rst_busy", busy, 0);
    check("s6_rst_div_signed", div_signed, 0);
    check("s6_rst_tag", out_tag, 0);
    check("s6_rst_div_x", div_x, 0);
    tick();
    resetn = 1'b1;

    out_ready = 1'b1;
    s0 = n_start;
    issue(7'h08, 32'd5, 32'd0, 5'd10);
`ifdef MULDIV_SCHED_DIV0_FAST_EN
    check("s6_div0_fast_valid", out_valid, 1);
`else
    wait_out(40, t);
`endif
    check("s6_div0_result", out_result, 32'hFFFF_FFFF);
    tick();
    check("s6_div0_starts", n_start - s0, DIV0_FAST ? 0 : 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 8);
      op = (r < 7) ? 7'(1 << r) : ((r == 7) ? 7'h00 : 7'h0C);
      a  = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 9);
        default: ;
      endcase
      tg  = TAG_W'($urandom);
      dly = $urandom_range(0, 3);
      is_mul = (op == 7'h01) || (op == 7'h02) || (op == 7'h04);
      is_div = (op == 7'h08) || (op == 7'h10) || (op == 7'h20) || (op == 7'h40);
      fast   = !is_mul && (!is_div || (DIV0_FAST && b == 32'd0));
      out_ready = 1'b0;
      s0 = n_start;
      issue(op, a, b, tg);
      wait_out(60, t);
      if (is_mul)    check("rnd_lat_mul", t, MUL_LAT + 1);
      else if (fast) check("rnd_lat_short", t, 1);
      else           check("rnd_lat_div", cyc, done_at + 1);
      check("rnd_result", out_result, ref_op(op, a, b));
      check("rnd_tag", out_tag, tg);
      repeat (dly) tick();
      check("rnd_hold", {out_valid, in_ready, out_result}, {1'b1, 1'b0, ref_op(op, a, b)});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("rnd_idle", busy, 0);
      check("rnd_starts", n_start - s0, (is_div && !fast) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
